// File: rtl/stream_packer.sv
// stream_packer: valid/ready width upsizer. Packs RATIO beats of IN_WIDTH bits
// little-endian into one registered IN_WIDTH*RATIO word with per-lane keep.
// s_last closes a partial word early. Optional macro
// STREAM_PACKER_FLUSH_TIMEOUT_EN adds an idle-timeout flush of partial words.
module stream_packer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [IN_WIDTH-1:0]       s_data,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [IN_WIDTH*RATIO-1:0] m_data,
  output logic [RATIO-1:0]          m_keep,
  output logic                      m_last
);
  localparam int OW = IN_WIDTH * RATIO;
  localparam int CW = $clog2(RATIO);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OW-1:0]    acc_q, acc_d;
  logic [RATIO-1:0] keep_q, keep_d;
  logic             m_valid_q, m_valid_d;
  logic [OW-1:0]    m_data_q, m_data_d;
  logic [RATIO-1:0] m_keep_q, m_keep_d;
  logic             m_last_q, m_last_d;
  logic             accept, closing;

`ifdef STREAM_PACKER_FLUSH_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT) + 1;
  logic [IW-1:0] idle_q, idle_d;
  logic          flush;
`endif

  // Output slot is free when empty or being drained this cycle.
  assign s_ready = !m_valid_q || m_ready;
  assign accept  = s_valid && s_ready;
  assign closing = accept && ((cnt_q == CW'(RATIO-1)) || s_last);

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_last  = m_last_q;

  // Next-state: lane fill, word close, drain and (optionally) timeout flush.
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    keep_d    = keep_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
`ifdef STREAM_PACKER_FLUSH_TIMEOUT_EN
    idle_d = idle_q;
    flush  = 1'b0;
`endif
    if (m_valid_q && m_ready) m_valid_d = 1'b0;
    if (accept) begin
      acc_d[int'(cnt_q)*IN_WIDTH +: IN_WIDTH] = s_data;
      keep_d[cnt_q] = 1'b1;
      if (closing) begin
        // Accumulator is cleared on every close, so unfilled lanes are 0.
        m_data_d  = acc_d;
        m_keep_d  = keep_d;
        m_last_d  = s_last;
        m_valid_d = 1'b1;
        acc_d     = '0;
        keep_d    = '0;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`ifdef STREAM_PACKER_FLUSH_TIMEOUT_EN
    if (accept) begin
      idle_d = '0;
    end else if (cnt_q != '0) begin
      // Counter saturates at TIMEOUT-1 while the output slot is busy.
      flush = (idle_q == IW'(TIMEOUT-1)) && s_ready;
      if (flush) begin
        m_data_d  = acc_q;
        m_keep_d  = keep_q;
        m_last_d  = 1'b0;
        m_valid_d = 1'b1;
        acc_d     = '0;
        keep_d    = '0;
        cnt_d     = '0;
        idle_d    = '0;
      end else if (idle_q != IW'(TIMEOUT-1)) begin
        idle_d = idle_q + 1'b1;
      end
    end
`endif
  end

  // State registers; reset drops both the partial word and any pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      keep_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      keep_q    <= keep_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
    end
  end

`ifdef STREAM_PACKER_FLUSH_TIMEOUT_EN
  // Idle counter for the partial-word flush.
  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`endif

endmodule

// File: tb/tb_stream_packer.sv
// Randomized + directed bench for stream_packer with a beat-queue reference model.
module tb_stream_packer;
  localparam int W = 8, R = 4, TO = 16, OW = W * R;

  logic          clk = 1'b0, rst = 1'b0;
  logic          s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_ready, m_valid, m_last;
  logic [OW-1:0] m_data;
  logic [R-1:0]  m_keep;

  int n_chk = 0, n_err = 0;

  // Reference model: beats of the open word, plus the expected output slot.
  logic [W-1:0]  cur[$];
  logic          e_valid = 1'b0, e_last = 1'b0;
  logic [OW-1:0] e_data = '0;
  logic [R-1:0]  e_keep = '0;
  int            idle = 0;

  stream_packer #(.IN_WIDTH(W), .RATIO(R), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_keep(m_keep), .m_last(m_last));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Close the model word from the collected beats.
  task automatic emit(input logic last);
    e_data = '0;
    foreach (cur[i]) e_data = e_data | (OW'(cur[i]) << (W * i));
    e_keep = R'((1 << cur.size()) - 1);
    e_last = last;
    e_valid = 1'b1;
    cur.delete();
    idle = 0;
  endtask

  // One clock: drive inputs, check s_ready, advance the model, check outputs.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic l, input logic r);
    logic sr, acc;
    s_valid = v; s_data = d; s_last = l; m_ready = r;
    #1;
    sr  = !e_valid || r;
    acc = v && sr;
    chk("s_ready", s_ready, sr);
    if (rst) begin
      cur.delete(); e_valid = 0; e_data = '0; e_keep = '0; e_last = 0; idle = 0;
    end else begin
      if (e_valid && r) e_valid = 1'b0;
      if (acc) begin
        cur.push_back(d);
        idle = 0;
        if (l || cur.size() == R) emit(l);
      end
`ifdef STREAM_PACKER_FLUSH_TIMEOUT_EN
      else if (cur.size() > 0) begin
        if (idle >= TO - 1 && sr) emit(1'b0);
        else idle++;
      end
`endif
    end
    @(posedge clk); #1;
    chk("m_valid", m_valid, e_valid);
    if (e_valid || rst) begin
      chk("m_data", m_data, e_data);
      chk("m_keep", m_keep, e_keep);
      chk("m_last", m_last, e_last);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int vz, rz, seen;
    do_reset();

    // Four beats fill one word; it must be visible for exactly one cycle.
    cycle(1, 8'h11, 0, 1); cycle(1, 8'h22, 0, 1);
    cycle(1, 8'h33, 0, 1); cycle(1, 8'h44, 0, 1);
    chk("word0", m_data, 32'h44332211);
    chk("keep0", m_keep, 4'hF);
    cycle(0, 8'h00, 0, 1);
    chk("word0_gone", m_valid, 1'b0);

    // Continuous stream of 12 beats.
    for (int i = 1; i <= 12; i++) cycle(1, W'(i), 0, 1);
    chk("word3", m_data, 32'h0C0B0A09);
    cycle(0, 8'h00, 0, 1);

    // s_last closes a two-lane word; next word restarts at lane 0.
    cycle(1, 8'hA1, 0, 1); cycle(1, 8'hA2, 1, 1);
    chk("short_data", m_data, 32'h0000A2A1);
    chk("short_keep", m_keep, 4'b0011);
    chk("short_last", m_last, 1'b1);
    cycle(1, 8'hB0, 1, 1);
    chk("single_keep", m_keep, 4'b0001);
    chk("single_data", m_data, 32'h000000B0);

    // Backpressure: word pending for 5 cycles, then drains.
    cycle(1, 8'hC1, 0, 1); cycle(1, 8'hC2, 0, 1);
    cycle(1, 8'hC3, 0, 1); cycle(1, 8'hC4, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 8'hD0, 0, 0);
    chk("bp_hold", m_data, 32'hC4C3C2C1);
    chk("bp_last", m_last, 1'b1);
    cycle(1, 8'hD1, 0, 1);
    cycle(0, 8'h00, 0, 1);

    // Reset mid-word discards accumulated beats.
    do_reset();
    cycle(1, 8'h01, 0, 1); cycle(1, 8'h02, 0, 1); cycle(1, 8'h03, 0, 1);
    do_reset();
    chk("rst_data", m_data, 32'h0);
    cycle(1, 8'h55, 0, 1); cycle(1, 8'h66, 0, 1);
    cycle(1, 8'h77, 0, 1); cycle(1, 8'h88, 0, 1);
    chk("post_rst", m_data, 32'h88776655);
    cycle(0, 8'h00, 0, 1);

`ifdef STREAM_PACKER_FLUSH_TIMEOUT_EN
    // Partial word flushes TIMEOUT cycles after the last accept.
    cycle(1, 8'h5A, 0, 1);
    seen = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle(0, 8'h00, 0, 1);
      if (m_valid && seen == 0) begin
        seen = 1;
        chk("flush_lat", k, TO);
        chk("flush_data", m_data, 32'h5A);
        chk("flush_keep", m_keep, 4'b0001);
      end
    end
    chk("flush_seen", seen, 1);
`endif

    // Randomized traffic with bounded idle / stall runs.
    vz = 0; rz = 0;
    for (int i = 0; i < 600; i++) begin
      logic v, r;
      v = ($urandom_range(0, 3) != 0) || (vz >= 3);
      r = ($urandom_range(0, 2) != 0) || (rz >= 3);
      vz = v ? 0 : vz + 1;
      rz = r ? 0 : rz + 1;
      cycle(v, W'($urandom), $urandom_range(0, 5) == 0, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
